// File: rtl/sram_march_bist.sv
// March C- self-test engine for the SRAM test array: drives shared port 0 plus one csb0 per
// channel, checks every read after RD_LAT cycles and keeps sticky per-channel results.
module sram_march_bist #(
    parameter int NUM_CH  = 16,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int WMASK_W = 4,
    parameter int RD_LAT  = 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic [ADDR_W-1:0]         addr_last,
    input  logic [DATA_W-1:0]         pattern,
    input  logic [NUM_CH*DATA_W-1:0]  dout_flat,
    output logic [ADDR_W-1:0]         addr0,
    output logic [DATA_W-1:0]         din0,
    output logic                      web0,
    output logic [WMASK_W-1:0]        wmask0,
    output logic [NUM_CH-1:0]         csb0,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_CH-1:0]         fail,
    output logic [$clog2(NUM_CH)-1:0] first_fail_ch,
    output logic [ADDR_W-1:0]         first_fail_addr,
    output logic [DATA_W-1:0]         first_fail_data,
    output logic [15:0]               fail_count
);
    // state | meaning
    // IDLE  | bus parked, waiting for start
    // RUN   | one march operation per cycle (elem_q, phase_q, addr_q)
    // DRAIN | bus parked, last RD_LAT read compares still in the pipe

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [2:0]          elem_q, elem_d;
    logic                phase_q, phase_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          drain_q, drain_d;
    logic [NUM_CH-1:0]   ch_en_q;
    logic [ADDR_W-1:0]   addr_last_q;
    logic [DATA_W-1:0]   pattern_q;
    logic                done_q;
    logic                ff_seen_q;

    logic                pipe_vld_q  [RD_LAT];
    logic [DATA_W-1:0]   pipe_exp_q  [RD_LAT];
    logic [ADDR_W-1:0]   pipe_addr_q [RD_LAT];

    logic                start_acc;
    logic                finish;
    logic                op_is_read;
    logic                rw_elem;
    logic                elem_down;
    logic                addr_end;
    logic                bg_one;
    logic [DATA_W-1:0]   op_data;
    logic                cmp_vld;
    logic [NUM_CH-1:0]   mism;
    logic [CH_W-1:0]     first_ch;
    logic [DATA_W-1:0]   first_data;

    assign start_acc = (state_q == S_IDLE) && start;
    assign finish    = (state_q == S_DRAIN) && (drain_q == 2'd0) && !abort;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        phase_d = phase_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        addr0   = '0;
        din0    = '0;
        web0    = 1'b1;
        csb0    = '1;
        wmask0  = '1;

        // Elements 0 and 5 are single-op; 1..4 are read-then-write pairs at one address.
        rw_elem    = (elem_q != 3'd0) && (elem_q != 3'd5);
        op_is_read = (elem_q != 3'd0) && !phase_q;
        elem_down  = (elem_q == 3'd3) || (elem_q == 3'd4);
        addr_end   = elem_down ? (addr_q == '0) : (addr_q == addr_last_q);
        if (op_is_read) bg_one = (elem_q == 3'd2) || (elem_q == 3'd4);
        else            bg_one = (elem_q == 3'd1) || (elem_q == 3'd3);
        op_data = bg_one ? ~pattern_q : pattern_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    elem_d  = 3'd0;
                    phase_d = 1'b0;
                    addr_d  = '0;
                    if (ch_enable != '0) state_d = S_RUN;
                end
            end
            S_RUN: begin
                addr0 = addr_q;
                din0  = op_data;
                web0  = op_is_read;
                csb0  = ~ch_en_q;
                if (rw_elem && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (!addr_end) begin
                        addr_d = elem_down ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
                    end else if (elem_q == 3'd5) begin
                        state_d = S_DRAIN;
                        drain_d = 2'(RD_LAT - 1);
                    end else begin
                        elem_d = elem_q + 3'd1;
                        // Elements 3 and 4 walk downward from the top address.
                        addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? addr_last_q : '0;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == 2'd0) state_d = S_IDLE;
                else                 drain_d = drain_q - 2'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    always_comb begin
        cmp_vld    = pipe_vld_q[RD_LAT-1] && !abort;
        mism       = '0;
        first_ch   = '0;
        first_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mism[c] = cmp_vld && ch_en_q[c] &&
                      (dout_flat[c*DATA_W +: DATA_W] != pipe_exp_q[RD_LAT-1]);
        end
        // Scan downward so the lowest failing channel is the one left standing.
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (mism[c]) begin
                first_ch   = CH_W'(c);
                first_data = dout_flat[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || abort || start_acc) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_exp_q[i]  <= '0;
                pipe_addr_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= (state_q == S_RUN) && op_is_read;
            pipe_exp_q[0]  <= op_data;
            pipe_addr_q[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_exp_q[i]  <= pipe_exp_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            elem_q          <= 3'd0;
            phase_q         <= 1'b0;
            addr_q          <= '0;
            drain_q         <= 2'd0;
            ch_en_q         <= '0;
            addr_last_q     <= '0;
            pattern_q       <= '0;
            done_q          <= 1'b0;
            fail            <= '0;
            first_fail_ch   <= '0;
            first_fail_addr <= '0;
            first_fail_data <= '0;
            fail_count      <= 16'd0;
            ff_seen_q       <= 1'b0;
        end else begin
            elem_q  <= elem_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            if (start_acc) begin
                ch_en_q         <= ch_enable;
                addr_last_q     <= addr_last;
                pattern_q       <= pattern;
                done_q          <= (ch_enable == '0);
                fail            <= '0;
                first_fail_ch   <= '0;
                first_fail_addr <= '0;
                first_fail_data <= '0;
                fail_count      <= 16'd0;
                ff_seen_q       <= 1'b0;
            end else begin
                if (finish) done_q <= 1'b1;
                if (mism != '0) begin
                    fail <= fail | mism;
                    if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
                    if (!ff_seen_q) begin
                        ff_seen_q       <= 1'b1;
                        first_fail_ch   <= first_ch;
                        first_fail_addr <= pipe_addr_q[RD_LAT-1];
                        first_fail_data <= first_data;
                    end
                end
            end
        end
    end

endmodule
